lfsr_seq_ctrl: RTL and testbench

//   Sequencer/configurator for the 8-bit LFSR keystream generator (existing LFSR module).
//   - Latches a job (taps, seed, warm-up count, length), seeds the LFSR and discards warm-up states.
//   - Streams successive LFSR states as keystream bytes over a valid/ready port.
//   - Sits between the cipher datapath (consumer) and the LFSR instance (sibling in the parent).

---
 rtl/lfsr_pkg.sv | 14 +
 rtl/lfsr8.sv | 28 ++
 rtl/lfsr_seq_ctrl.sv | 100 ++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and state type for the LFSR keystream sequencer.
package lfsr_pkg;

    localparam int LFSR_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WARMUP,
        RUN,
        DONE
    } lfsr_seq_state_t;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR: shifts left, feedback is the parity of the tapped bits into bit 0.
module lfsr8
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              en,
    input  logic [LFSR_W-1:0] tap,
    input  logic [LFSR_W-1:0] init_state,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
        end else if (init) begin
            state_q <= init_state;
        end else if (en) begin
            state_q <= {state_q[LFSR_W-2:0], ^(state_q & tap)};
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Job sequencer for the LFSR keystream generator: seeds the LFSR, discards warm-up
// states, then streams LFSR states as keystream bytes over a valid/ready port.
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned SKIP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LFSR_W-1:0] cfg_tap,
    input  logic [LFSR_W-1:0] cfg_seed,
    input  logic [SKIP_W-1:0] cfg_skip,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              ks_valid,
    input  logic              ks_ready,
    output logic [LFSR_W-1:0] ks_data,
    output logic              ks_last,
    output logic              lfsr_init,
    output logic              lfsr_en,
    output logic [LFSR_W-1:0] lfsr_tab,
    output logic [LFSR_W-1:0] lfsr_init_state,
    input  logic [LFSR_W-1:0] lfsr_state
);

    lfsr_seq_state_t   state_q, state_d;
    logic [LFSR_W-1:0] tap_q, seed_q;
    logic [SKIP_W-1:0] skip_cnt_q;
    logic [LEN_W-1:0]  len_q, byte_cnt_q;
    logic              zero_done_q;
    logic              accept_job, zero_job, xfer;

    // abort beats start when both arrive in IDLE
    assign accept_job = (state_q == IDLE) && start && !abort && (cfg_len != '0);
    assign zero_job   = (state_q == IDLE) && start && !abort && (cfg_len == '0);
    assign xfer       = ks_valid && ks_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tap_q       <= '0;
            seed_q      <= '0;
            skip_cnt_q  <= '0;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            zero_done_q <= zero_job;
            if (accept_job) begin
                tap_q      <= cfg_tap;
                seed_q     <= cfg_seed;
                skip_cnt_q <= cfg_skip;
                len_q      <= cfg_len;
                byte_cnt_q <= '0;
            end
            if (state_q == WARMUP && !abort) begin
                skip_cnt_q <= skip_cnt_q - SKIP_W'(1);
            end
            if (xfer) begin
                byte_cnt_q <= byte_cnt_q + LEN_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) begin
            if (accept_job) state_d = LOAD;
        end else if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                LOAD:    state_d = (skip_cnt_q != '0) ? WARMUP : RUN;
                WARMUP:  if (skip_cnt_q == SKIP_W'(1)) state_d = RUN;
                RUN:     if (xfer && ks_last) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // abort suppresses every strobe in the cycle it is seen
    always_comb begin
        busy            = (state_q != IDLE);
        done            = ((state_q == DONE) && !abort) || zero_done_q;
        ks_valid        = (state_q == RUN) && !abort;
        ks_last         = ks_valid && (byte_cnt_q == len_q - LEN_W'(1));
        ks_data         = lfsr_state;
        lfsr_init       = (state_q == LOAD) && !abort;
        lfsr_en         = ((state_q == WARMUP) && !abort) || (ks_valid && ks_ready);
        lfsr_tab        = tap_q;
        lfsr_init_state = seed_q;
    end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench: job-level reference model, directed scenarios and random traffic.
module tb_lfsr_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, abort, ks_ready;
    logic [7:0]  cfg_tap, cfg_seed, cfg_skip;
    logic [15:0] cfg_len;
    logic        busy, done, ks_valid, ks_last, lfsr_init, lfsr_en;
    logic [7:0]  ks_data, lfsr_tab, lfsr_init_state, lfsr_state;

    always #5 clk = ~clk;

    lfsr_seq_ctrl #(.LEN_W(16), .SKIP_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_tap(cfg_tap), .cfg_seed(cfg_seed),
        .cfg_skip(cfg_skip), .cfg_len(cfg_len), .abort(abort), .busy(busy), .done(done),
        .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data), .ks_last(ks_last),
        .lfsr_init(lfsr_init), .lfsr_en(lfsr_en), .lfsr_tab(lfsr_tab),
        .lfsr_init_state(lfsr_init_state), .lfsr_state(lfsr_state)
    );

    lfsr8 u_lfsr (
        .clk(clk), .reset(reset), .init(lfsr_init), .en(lfsr_en), .tap(lfsr_tab),
        .init_state(lfsr_init_state), .state(lfsr_state)
    );

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    // Job-level model: phase derived from cycles since start and bytes delivered.
    bit         m_act, m_dp;
    int         m_t, m_skip, m_len, m_sent;
    logic [7:0] m_tap, m_seed;

    // Observation record for directed scenarios
    logic [7:0] got_q[$];
    bit         last_q[$];
    int first_v, last_cyc, done_cyc, done_cnt, warm_en, stall_cnt, init_cnt, busy_cnt;

    function automatic logic [7:0] lfsr_at(logic [7:0] s, logic [7:0] t, int n);
        for (int i = 0; i < n; i++) s = {s[6:0], ^(s & t)};
        return s;
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        logic e_busy, e_done, e_valid, e_last, e_init, e_en;
        logic [7:0] e_data;
        e_busy = m_act; e_done = 0; e_valid = 0; e_last = 0; e_init = 0; e_en = 0;
        e_data = '0;
        if (!m_act) begin
            e_done = m_dp;
        end else if (m_t == 1) begin
            e_init = !abort;
        end else if (m_t <= 1 + m_skip) begin
            e_en = !abort;
        end else if (m_sent < m_len) begin
            e_valid = !abort;
            e_last  = e_valid && (m_sent == m_len - 1);
            e_en    = e_valid && ks_ready;
            e_data  = lfsr_at(m_seed, m_tap, m_skip + m_sent);
        end else begin
            e_done = !abort;
        end
        chk("busy", 16'(busy), 16'(e_busy));
        chk("done", 16'(done), 16'(e_done));
        chk("ks_valid", 16'(ks_valid), 16'(e_valid));
        chk("lfsr_init", 16'(lfsr_init), 16'(e_init));
        chk("lfsr_en", 16'(lfsr_en), 16'(e_en));
        chk("init_en_excl", 16'(lfsr_init & lfsr_en), 16'(0));
        if (e_valid) begin
            chk("ks_data", 16'(ks_data), 16'(e_data));
            chk("ks_last", 16'(ks_last), 16'(e_last));
        end
        if (e_init) begin
            chk("lfsr_tab", 16'(lfsr_tab), 16'(m_tap));
            chk("lfsr_init_state", 16'(lfsr_init_state), 16'(m_seed));
        end
        // observation for directed literal checks
        if (ks_valid && ks_ready) begin
            got_q.push_back(ks_data);
            last_q.push_back(ks_last);
            last_cyc = cyc;
        end
        if (ks_valid && first_v < 0) first_v = cyc;
        if (ks_valid && !ks_ready) stall_cnt++;
        if (lfsr_en && !ks_valid) warm_en++;
        if (lfsr_init) init_cnt++;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_act = 0;
            m_dp  = 0;
        end else if (m_act) begin
            m_dp = 0;
            if (abort) begin
                m_act = 0;
            end else if (m_t > 1 + m_skip && m_sent == m_len) begin
                m_act = 0;
            end else begin
                if (m_t > 1 + m_skip && ks_ready) m_sent++;
                m_t++;
            end
        end else begin
            m_dp = start && !abort && (cfg_len == 0);
            if (start && !abort && cfg_len != 0) begin
                m_act = 1; m_t = 1; m_sent = 0;
                m_tap = cfg_tap; m_seed = cfg_seed;
                m_skip = int'(cfg_skip); m_len = int'(cfg_len);
            end
        end
    endtask

    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_obs();
        got_q.delete();
        last_q.delete();
        first_v = -1; last_cyc = -1; done_cyc = -1;
        done_cnt = 0; warm_en = 0; stall_cnt = 0; init_cnt = 0; busy_cnt = 0;
    endtask

    task automatic start_job(logic [7:0] t, logic [7:0] s, logic [7:0] k, logic [15:0] l);
        cfg_tap = t; cfg_seed = s; cfg_skip = k; cfg_len = l;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((m_act || m_dp) && n < budget) begin
            tick();
            n++;
        end
        if (m_act || m_dp) begin
            errs++;
            $display("FAIL drain_timeout cyc=%0d actual=busy required=idle", cyc);
        end
    endtask

    int sc;

    initial begin
        reset = 1; start = 0; abort = 0; ks_ready = 1;
        cfg_tap = 0; cfg_seed = 0; cfg_skip = 0; cfg_len = 0;
        m_act = 0; m_dp = 0; m_t = 0; m_skip = 0; m_len = 0; m_sent = 0;
        m_tap = 0; m_seed = 0;
        clear_obs();
        @(negedge clk);
        @(negedge clk);
        tick();
        reset = 0;

        // pin the reference LFSR stepping against hand-worked values
        chk("model_step3", 16'(lfsr_at(8'h01, 8'hB8, 3)), 16'h08);
        chk("model_step5", 16'(lfsr_at(8'h01, 8'hB8, 5)), 16'h23);
        chk("model_80", 16'(lfsr_at(8'h80, 8'hB8, 1)), 16'h01);

        // 1: basic job
        clear_obs();
        sc = cyc;
        start_job(8'hB8, 8'h01, 8'd0, 16'd4);
        drain(50);
        chk("t1_len", 16'(got_q.size()), 16'd4);
        if (got_q.size() == 4) begin
            chk("t1_b0", 16'(got_q[0]), 16'h01);
            chk("t1_b1", 16'(got_q[1]), 16'h02);
            chk("t1_b2", 16'(got_q[2]), 16'h04);
            chk("t1_b3", 16'(got_q[3]), 16'h08);
            chk("t1_last", 16'({last_q[0], last_q[1], last_q[2], last_q[3]}), 16'b0001);
        end
        chk("t1_latency", 16'(first_v - sc), 16'd2);
        chk("t1_done_gap", 16'(done_cyc - last_cyc), 16'd1);
        chk("t1_done_cnt", 16'(done_cnt), 16'd1);
        tick();

        // 2: warm-up discards three states
        clear_obs();
        sc = cyc;
        start_job(8'hB8, 8'h01, 8'd3, 16'd3);
        drain(50);
        chk("t2_latency", 16'(first_v - sc), 16'd5);
        chk("t2_warm_en", 16'(warm_en), 16'd3);
        chk("t2_len", 16'(got_q.size()), 16'd3);
        if (got_q.size() == 3) begin
            chk("t2_b0", 16'(got_q[0]), 16'h08);
            chk("t2_b1", 16'(got_q[1]), 16'h11);
            chk("t2_b2", 16'(got_q[2]), 16'h23);
        end
        tick();

        // 3: consumer stalls three cycles on byte 02
        clear_obs();
        sc = cyc;
        start_job(8'hB8, 8'h01, 8'd0, 16'd4);
        for (int i = 0; i < 40 && (m_act || m_dp); i++) begin
            ks_ready = !(cyc >= sc + 3 && cyc <= sc + 5);
            tick();
        end
        ks_ready = 1;
        drain(10);
        chk("t3_stall", 16'(stall_cnt), 16'd3);
        chk("t3_len", 16'(got_q.size()), 16'd4);
        if (got_q.size() == 4) begin
            chk("t3_b1", 16'(got_q[1]), 16'h02);
            chk("t3_b3", 16'(got_q[3]), 16'h08);
        end
        tick();

        // 4: zero-length job
        clear_obs();
        start_job(8'hB8, 8'h01, 8'd0, 16'd0);
        tick();
        chk("t4_done", 16'(done_cnt), 16'd1);
        chk("t4_init", 16'(init_cnt), 16'd0);
        chk("t4_busy", 16'(busy_cnt), 16'd0);
        tick();

        // 5: abort after byte 02, then clean restart with a start ignored while busy
        clear_obs();
        start_job(8'hB8, 8'h01, 8'd0, 16'd4);
        for (int i = 0; i < 20 && got_q.size() < 2; i++) tick();
        abort = 1;
        tick();
        abort = 0;
        #1;
        chk("t5_idle", 16'(busy), 16'd0);
        tick();
        chk("t5_no_done", 16'(done_cnt), 16'd0);
        clear_obs();
        start_job(8'hB8, 8'h80, 8'd0, 16'd2);
        cfg_seed = 8'hFF; cfg_len = 16'd1;
        start = 1;
        tick();
        start = 0;
        drain(20);
        chk("t5_len", 16'(got_q.size()), 16'd2);
        if (got_q.size() == 2) begin
            chk("t5_b0", 16'(got_q[0]), 16'h80);
            chk("t5_b1", 16'(got_q[1]), 16'h01);
        end
        tick();

        // reset in the middle of warm-up
        start_job(8'hB8, 8'h01, 8'd5, 16'd3);
        tick();
        tick();
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_en", 16'(lfsr_en), 16'd0);
        chk("rst_valid", 16'(ks_valid), 16'd0);
        tick();

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            start    = ($urandom_range(0, 5) == 0);
            cfg_tap  = 8'($urandom);
            cfg_seed = 8'($urandom);
            cfg_skip = 8'($urandom_range(0, 6));
            cfg_len  = 16'($urandom_range(0, 9));
            ks_ready = ($urandom_range(0, 3) != 0);
            abort    = ($urandom_range(0, 39) == 0);
            reset    = ($urandom_range(0, 599) == 0);
            tick();
        end
        start = 0; abort = 0; reset = 0; ks_ready = 1;
        drain(400);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
